// File: rtl/wb_stage_pkg.sv
// Shared pipeline constants and types for the write-back stage.
// Control-bit positions match the control word produced by the decoder.
package wb_stage_pkg;

    localparam int SIZE         = 32;
    localparam int IDX_W        = $clog2(SIZE);
    localparam int CTL_W        = 11;
    localparam int CTL_REGWRITE = 10;
    localparam int CTL_MEMWRITE = 8;
    localparam int CTL_MEMREAD  = 6;

    typedef logic [SIZE-1:0]  word_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic  valid;
        idx_t  rd;
        word_t data;
    } fwd_t;

endpackage

// File: rtl/wb_stage_regfile.sv
// Register array with two write-bypassed read ports and one raw debug port.
// Register 0 is hardwired to zero.
module regfile
    import wb_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  we,
    input  idx_t  waddr,
    input  word_t wdata,
    input  idx_t  rs_addr,
    input  idx_t  rt_addr,
    output word_t rs_data,
    output word_t rt_data,
    input  idx_t  dbg_addr,
    output word_t dbg_data
);

    word_t regs_q [SIZE];
    word_t regs_d [SIZE];

    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SIZE; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // we never targets index 0, so the bypass cannot leak data onto register 0
    always_comb begin
        rs_data = regs_q[rs_addr];
        rt_data = regs_q[rt_addr];
        if (we && (rs_addr == waddr)) begin
            rs_data = wdata;
        end
        if (we && (rt_addr == waddr)) begin
            rt_data = wdata;
        end
    end

    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: result select, register file update, EX forwarding
// record and retired-instruction counter.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             validMEM,
    input  logic [CTL_W-1:0] controlMEM,
    input  logic [IDX_W-1:0] writeRegMEM,
    input  logic [SIZE-1:0]  data,
    input  logic [SIZE-1:0]  ALUresultMEM,
    input  logic [IDX_W-1:0] rsAddr,
    input  logic [IDX_W-1:0] rtAddr,
    output logic [SIZE-1:0]  rsData,
    output logic [SIZE-1:0]  rtData,
    input  logic [IDX_W-1:0] dbgAddr,
    output logic [SIZE-1:0]  dbgData,
    output logic             fwdValid,
    output logic [IDX_W-1:0] fwdReg,
    output logic [SIZE-1:0]  fwdData,
    output logic [31:0]      retired
);

    word_t       wb_data;
    logic        wb_en;
    fwd_t        fwd_q, fwd_d;
    logic [31:0] retired_q, retired_d;
    logic        ctl_unused;

    assign ctl_unused = ^{controlMEM[CTL_REGWRITE-1:CTL_MEMREAD+1],
                          controlMEM[CTL_MEMREAD-1:0]};

    // rst_n gates the enable so nothing bypasses onto the read ports in reset
    always_comb begin
        wb_data = controlMEM[CTL_MEMREAD] ? data : ALUresultMEM;
        wb_en   = rst_n && validMEM && controlMEM[CTL_REGWRITE]
                  && (writeRegMEM != '0);
    end

    always_comb begin
        fwd_d       = fwd_q;
        fwd_d.valid = wb_en;
        if (wb_en) begin
            fwd_d.rd   = writeRegMEM;
            fwd_d.data = wb_data;
        end
        retired_d = validMEM ? retired_q + 32'd1 : retired_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q     <= '0;
            retired_q <= '0;
        end else begin
            fwd_q     <= fwd_d;
            retired_q <= retired_d;
        end
    end

    regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (wb_en),
        .waddr    (writeRegMEM),
        .wdata    (wb_data),
        .rs_addr  (rsAddr),
        .rt_addr  (rtAddr),
        .rs_data  (rsData),
        .rt_data  (rtData),
        .dbg_addr (dbgAddr),
        .dbg_data (dbgData)
    );

    assign fwdValid = fwd_q.valid;
    assign fwdReg   = fwd_q.rd;
    assign fwdData  = fwd_q.data;
    assign retired  = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage with hand-computed expectations.
module tb_wb_stage;

   logic        clk;
   logic        rst_n;
   logic        validMEM;
   logic [10:0] controlMEM;
   logic [4:0]  writeRegMEM;
   logic [31:0] data;
   logic [31:0] ALUresultMEM;
   logic [4:0]  rsAddr;
   logic [4:0]  rtAddr;
   logic [31:0] rsData;
   logic [31:0] rtData;
   logic [4:0]  dbgAddr;
   logic [31:0] dbgData;
   logic        fwdValid;
   logic [4:0]  fwdReg;
   logic [31:0] fwdData;
   logic [31:0] retired;

   int checksTotal;
   int checksPassed;

   localparam logic [10:0] CTL_LOAD  = 11'h440;
   localparam logic [10:0] CTL_ALU   = 11'h400;
   localparam logic [10:0] CTL_STORE = 11'h100;
   localparam logic [10:0] CTL_NONE  = 11'h000;

   wb_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .validMEM     (validMEM),
      .controlMEM   (controlMEM),
      .writeRegMEM  (writeRegMEM),
      .data         (data),
      .ALUresultMEM (ALUresultMEM),
      .rsAddr       (rsAddr),
      .rtAddr       (rtAddr),
      .rsData       (rsData),
      .rtData       (rtData),
      .dbgAddr      (dbgAddr),
      .dbgData      (dbgData),
      .fwdValid     (fwdValid),
      .fwdReg       (fwdReg),
      .fwdData      (fwdData),
      .retired      (retired)
   );

   // 10-unit clock, posedge at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compares one observed value against its expected value and tallies it
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checksTotal++;
      if (got !== exp) begin
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         checksPassed++;
      end
   endtask

   // Drives one MEM/WB slot just after a negedge, away from the active edge
   task automatic applyStimulus(input logic v, input logic [10:0] ctl, input logic [4:0] wr,
                                input logic [31:0] ld, input logic [31:0] alu,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dbg);
      @(negedge clk);
      validMEM     = v;
      controlMEM   = ctl;
      writeRegMEM  = wr;
      data         = ld;
      ALUresultMEM = alu;
      rsAddr       = rs;
      rtAddr       = rt;
      dbgAddr      = dbg;
      #1;
   endtask

   // Advances through the next active edge and settles
   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   // Sequence of directed vectors covering write, bypass, forwarding, retire wrap and reset
   initial begin
      checksTotal  = 0;
      checksPassed = 0;
      rst_n        = 1'b0;
      validMEM     = 1'b0;
      controlMEM   = CTL_NONE;
      writeRegMEM  = 5'd0;
      data         = 32'd0;
      ALUresultMEM = 32'd0;
      rsAddr       = 5'd0;
      rtAddr       = 5'd0;
      dbgAddr      = 5'd0;
      #1;
      checkOutput("reset_retired", retired, 32'd0);
      checkOutput("reset_fwdValid", {31'd0, fwdValid}, 32'd0);
      checkOutput("reset_rsData", rsData, 32'd0);
      repeat (2) stepEdge();
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(1'b1, CTL_LOAD, 5'd8, 32'hDEADBEEF, 32'h00001234, 5'd8, 5'd8, 5'd8);
      checkOutput("load_rs_bypass", rsData, 32'hDEADBEEF);
      checkOutput("load_rt_bypass", rtData, 32'hDEADBEEF);
      checkOutput("load_dbg_before", dbgData, 32'd0);
      stepEdge();
      checkOutput("load_dbg_after", dbgData, 32'hDEADBEEF);
      checkOutput("load_fwdValid", {31'd0, fwdValid}, 32'd1);
      checkOutput("load_fwdReg", {27'd0, fwdReg}, 32'd8);
      checkOutput("load_fwdData", fwdData, 32'hDEADBEEF);
      checkOutput("load_retired", retired, 32'd1);

      applyStimulus(1'b1, CTL_ALU, 5'd0, 32'hxxxxxxxx, 32'd5, 5'd0, 5'd0, 5'd0);
      checkOutput("r0_rs_read", rsData, 32'd0);
      stepEdge();
      checkOutput("r0_dbg", dbgData, 32'd0);
      checkOutput("r0_fwdValid", {31'd0, fwdValid}, 32'd0);
      checkOutput("r0_fwdReg_hold", {27'd0, fwdReg}, 32'd8);
      checkOutput("r0_fwdData_hold", fwdData, 32'hDEADBEEF);
      checkOutput("r0_retired", retired, 32'd2);

      applyStimulus(1'b1, CTL_ALU, 5'd9, 32'd0, 32'd1, 5'd9, 5'd9, 5'd9);
      checkOutput("b2b_rs_first", rsData, 32'd1);
      checkOutput("b2b_rt_first", rtData, 32'd1);
      stepEdge();
      applyStimulus(1'b1, CTL_ALU, 5'd9, 32'd0, 32'd2, 5'd9, 5'd9, 5'd9);
      checkOutput("b2b_rs_second", rsData, 32'd2);
      checkOutput("b2b_rt_second", rtData, 32'd2);
      checkOutput("b2b_dbg_mid", dbgData, 32'd1);
      stepEdge();
      applyStimulus(1'b0, CTL_NONE, 5'd0, 32'd0, 32'd0, 5'd9, 5'd9, 5'd9);
      checkOutput("b2b_rs_reg", rsData, 32'd2);
      checkOutput("b2b_dbg", dbgData, 32'd2);
      checkOutput("b2b_fwdData", fwdData, 32'd2);
      checkOutput("b2b_retired", retired, 32'd4);

      applyStimulus(1'b1, CTL_STORE, 5'd9, 32'hxxxxxxxx, 32'd77, 5'd9, 5'd9, 5'd9);
      checkOutput("store_rs_nobypass", rsData, 32'd2);
      stepEdge();
      checkOutput("store_dbg", dbgData, 32'd2);
      checkOutput("store_fwdValid", {31'd0, fwdValid}, 32'd0);
      checkOutput("store_retired", retired, 32'd5);

      applyStimulus(1'b0, CTL_ALU, 5'd10, 32'd0, 32'h55, 5'd10, 5'd10, 5'd10);
      checkOutput("invalid_rs", rsData, 32'd0);
      stepEdge();
      checkOutput("invalid_dbg", dbgData, 32'd0);
      checkOutput("invalid_retired", retired, 32'd5);

      applyStimulus(1'b0, CTL_NONE, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
      dut.retired_q = 32'hFFFFFFFE;
      applyStimulus(1'b1, CTL_NONE, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
      stepEdge();
      checkOutput("wrap_ffffffff", retired, 32'hFFFFFFFF);
      stepEdge();
      checkOutput("wrap_zero", retired, 32'd0);
      stepEdge();
      checkOutput("wrap_one", retired, 32'd1);

      applyStimulus(1'b1, CTL_ALU, 5'd4, 32'd0, 32'hAA, 5'd4, 5'd4, 5'd4);
      stepEdge();
      applyStimulus(1'b1, CTL_ALU, 5'd3, 32'd0, 32'h33, 5'd3, 5'd4, 5'd4);
      checkOutput("prerst_rs_bypass", rsData, 32'h33);
      checkOutput("prerst_rt_reg4", rtData, 32'hAA);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_rs", rsData, 32'd0);
      checkOutput("rst_rt", rtData, 32'd0);
      checkOutput("rst_dbg4", dbgData, 32'd0);
      checkOutput("rst_fwdValid", {31'd0, fwdValid}, 32'd0);
      checkOutput("rst_fwdReg", {27'd0, fwdReg}, 32'd0);
      checkOutput("rst_fwdData", fwdData, 32'd0);
      checkOutput("rst_retired", retired, 32'd0);
      stepEdge();
      checkOutput("rst_hold_retired", retired, 32'd0);
      checkOutput("rst_hold_rs", rsData, 32'd0);
      applyStimulus(1'b0, CTL_NONE, 5'd0, 32'd0, 32'd0, 5'd3, 5'd3, 5'd3);
      rst_n = 1'b1;
      #1;
      checkOutput("post_rst_dbg3", dbgData, 32'd0);
      checkOutput("post_rst_rs3", rsData, 32'd0);

      applyStimulus(1'b1, CTL_ALU, 5'd3, 32'd0, 32'h77, 5'd3, 5'd3, 5'd3);
      stepEdge();
      checkOutput("post_rst_write", dbgData, 32'h77);
      checkOutput("post_rst_retired", retired, 32'd1);
      checkOutput("post_rst_fwdReg", {27'd0, fwdReg}, 32'd3);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SIZE, 32, datapath width and register count; register index width is $clog2(SIZE).
REQ-002 clk  input  1  pipeline clock; all state changes on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 validMEM  input  1  instruction present in the MEM/WB slot this cycle.
REQ-005 controlMEM  input  11  control word from MEM: bit 10 RegWrite, bit 6 MemRead (load; selects memory data).
REQ-006 writeRegMEM  input  $clog2(SIZE)  destination register index.
REQ-007 data  input  SIZE  load data from the MEM stage.
REQ-008 ALUresultMEM  input  SIZE  ALU result carried through MEM.
REQ-009 rsAddr, rtAddr  input  $clog2(SIZE) each  ID-stage read addresses.
REQ-010 rsData, rtData  output  SIZE each  ID-stage read data, combinational.
REQ-011 dbgAddr  input  $clog2(SIZE)  debug read address; dbgData  output  SIZE  debug read data, combinational, no bypass.
REQ-012 fwdValid  output  1; fwdReg  output  $clog2(SIZE); fwdData  output  SIZE  registered record of the last committed write, for EX forwarding.
REQ-013 retired  output  32  count of retired instructions.

Function
REQ-014 wbData SHALL be data when controlMEM[6]=1, otherwise ALUresultMEM.
REQ-015 wbEn SHALL be validMEM && controlMEM[10] && writeRegMEM != 0.
REQ-016 When wbEn=1, register[writeRegMEM] SHALL take wbData at the next posedge; no other register changes.
REQ-017 Register 0 SHALL always read 0; a write to index 0 SHALL be discarded and SHALL NOT set fwdValid.
REQ-018 rsData/rtData SHALL bypass: if wbEn=1 and the address equals writeRegMEM, output wbData in the same cycle; otherwise output register content.
REQ-019 Both read ports addressing the same register SHALL return identical values, bypass included.
REQ-020 On each posedge fwdValid SHALL take wbEn; when wbEn=1, fwdReg/fwdData SHALL take writeRegMEM/wbData; otherwise they hold.
REQ-021 retired SHALL increment by 1 on each posedge with validMEM=1 and wrap from 32'hFFFFFFFF to 0.
REQ-022 A valid slot with RegWrite=0 (store, branch) SHALL retire without writing and SHALL clear fwdValid.
REQ-023 Write latency: one edge; the written value is visible on dbgData in the cycle after the edge, and on rsData/rtData in the same cycle via bypass.
REQ-024 X on data or ALUresultMEM SHALL NOT propagate when wbEn=0.

Reset
REQ-025 rst_n low SHALL clear every register, fwdValid, fwdReg, fwdData and retired to 0 immediately, without waiting for clk.
REQ-026 A write pending when rst_n falls SHALL be lost; while rst_n is low no write, bypass or count update SHALL occur, and rsData/rtData SHALL read 0.
REQ-027 The first posedge after rst_n rises SHALL behave as normal operation.

Structure
REQ-028 A shared pipeline package SHALL hold the control-bit positions (CTL_REGWRITE=10, CTL_MEMREAD=6, CTL_MEMWRITE=8), the control width 11 and SIZE.
REQ-029 The register array with two bypassed read ports and the debug port SHALL be one sub-module, regfile; wb_stage SHALL hold the wbData mux, forwarding record and retire counter.

Verification
REQ-030 Reset, then valid load (ctl[10]=1, ctl[6]=1), writeReg=8, data=32'hDEADBEEF -> rsAddr=8 reads DEADBEEF in the same cycle; dbgData(8)=DEADBEEF next cycle; fwdValid=1, fwdReg=8.
REQ-031 Valid ALU op (ctl[10]=1, ctl[6]=0), writeReg=0, ALUresult=5 -> reg0 stays 0, fwdValid=0, retired increments by 1.
REQ-032 Back-to-back writes to reg 9 (value 1, then 2) with rsAddr=rtAddr=9 -> reads 1, then 2, with no stale cycle.
REQ-033 Store slot (ctl[8]=1, ctl[10]=0), validMEM=1 -> no register changes, fwdValid=0, retired+1.
REQ-034 Preload retired=32'hFFFFFFFE, apply 3 valid slots -> FFFFFFFF, 0, 1.
REQ-035 Assert rst_n low between edges with a write pending to reg 3 -> all outputs 0 immediately; reg 3 = 0 after release.
